// File: rtl/dcache_if.sv
// Bus bundle between the core, the data cache controller and main memory.
// master = cache controller view; slave = core/memory environment view.
interface dcache_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_ack;

  modport master (
    input  mem_read, mem_write, cpu_addr, cpu_wdata, mem_rdata, mem_rvalid, mem_ack,
    output cpu_rdata, cpu_stall, mem_rd_req, mem_wr_req, mem_addr, mem_wdata
  );

  modport slave (
    output mem_read, mem_write, cpu_addr, cpu_wdata, mem_rdata, mem_rvalid, mem_ack,
    input  cpu_rdata, cpu_stall, mem_rd_req, mem_wr_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Hits return in the same cycle; misses and all stores stall the core.
module dcache_controller #(
  parameter int NUM_BLOCKS  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic      clk,
  input  logic      rst,
  dcache_if.master  bus
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam int LINE_BYTES = BLOCK_WORDS * 4;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);
  localparam logic [31:0] LINE_MASK = 32'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                  state_reg;
  logic [NUM_BLOCKS-1:0]   valid_reg;
  logic [OFF_W-1:0]        beat_reg;
  logic                    rd_req_reg;
  logic                    wr_req_reg;
  logic [31:0]             mem_addr_reg;
  logic [31:0]             mem_wdata_reg;

  logic [TAG_W-1:0]        tag_mem  [NUM_BLOCKS];
  logic [31:0]             data_mem [NUM_BLOCKS*BLOCK_WORDS];

  logic [TAG_W-1:0]        cpu_tag;
  logic [IDX_W-1:0]        cpu_idx;
  logic [OFF_W-1:0]        cpu_off;
  logic [TAG_W-1:0]        fill_tag;
  logic [IDX_W-1:0]        fill_idx;
  logic                    hit;
  logic                    fill_beat;
  logic                    fill_done;
  logic [NUM_BLOCKS-1:0]   fill_set;
  logic                    data_we;
  logic [IDX_W+OFF_W-1:0]  data_waddr;
  logic [31:0]             data_wdata;

  assign cpu_tag = bus.cpu_addr[31 -: TAG_W];
  assign cpu_idx = bus.cpu_addr[2+OFF_W +: IDX_W];
  assign cpu_off = bus.cpu_addr[2 +: OFF_W];

  // During a fill the core address is ignored; the line is located by the latched block address.
  assign fill_tag = mem_addr_reg[31 -: TAG_W];
  assign fill_idx = mem_addr_reg[2+OFF_W +: IDX_W];

  assign hit       = valid_reg[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign fill_beat = !rst && (state_reg == FILL) && bus.mem_rvalid;
  assign fill_done = fill_beat && (beat_reg == LAST_BEAT);

  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_fill_set
    assign fill_set[gi] = fill_done && (fill_idx == IDX_W'(gi));
  end

  always_comb begin
    data_we    = 1'b0;
    data_waddr = {cpu_idx, cpu_off};
    data_wdata = bus.cpu_wdata;
    if (fill_beat) begin
      data_we    = 1'b1;
      data_waddr = {fill_idx, beat_reg};
      data_wdata = bus.mem_rdata;
    end else if (!rst && (state_reg == IDLE) && bus.mem_write && hit) begin
      data_we    = 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[data_waddr] <= data_wdata;
    end
    if (fill_done) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      beat_reg      <= '0;
      rd_req_reg    <= 1'b0;
      wr_req_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A store wins over a load if the decoder ever raises both.
          if (bus.mem_write) begin
            mem_addr_reg  <= bus.cpu_addr & ~32'h3;
            mem_wdata_reg <= bus.cpu_wdata;
            wr_req_reg    <= 1'b1;
            state_reg     <= WRITE;
          end else if (bus.mem_read && !hit) begin
            mem_addr_reg  <= bus.cpu_addr & ~LINE_MASK;
            beat_reg      <= '0;
            rd_req_reg    <= 1'b1;
            state_reg     <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_rvalid) begin
            beat_reg <= beat_reg + OFF_W'(1);
            if (beat_reg == LAST_BEAT) begin
              valid_reg  <= valid_reg | fill_set;
              rd_req_reg <= 1'b0;
              state_reg  <= DONE;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            wr_req_reg <= 1'b0;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          // Core retires here; returning to IDLE next keeps a held store from re-issuing.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.cpu_stall = 1'b0;
    case (state_reg)
      IDLE:        bus.cpu_stall = bus.mem_write || (bus.mem_read && !hit);
      FILL, WRITE: bus.cpu_stall = 1'b1;
      default:     bus.cpu_stall = 1'b0;
    endcase
  end

  assign bus.cpu_rdata  = data_mem[{cpu_idx, cpu_off}];
  assign bus.mem_rd_req = rd_req_reg;
  assign bus.mem_wr_req = wr_req_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;

endmodule
